// File: rtl/sram_counter_emulator.sv
// Loopback stand-in for the demo board's 12-bit ripple counter and two nibble-wide SRAM slices.
// Optional macro SRAM_EMU_FAULT_INJECT_EN adds FAULT_ADDR and flips read bit 0 at that address.
module sram_counter_emulator #(
  parameter int CNT_W    = 12,
  parameter int MEM_AW   = 4,
  parameter int NIB_W    = 4,
  parameter int TURN_CYC = 1
`ifdef SRAM_EMU_FAULT_INJECT_EN
  ,
  parameter int FAULT_ADDR = 5
`endif
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               COUNTER_CLK,
  input  logic               COUNTER_RST,
  input  logic               WE_BAR,
  input  logic [NIB_W-1:0]   CHIP1_DATA_IN,
  input  logic [NIB_W-1:0]   CHIP2_DATA_IN,
  output logic [NIB_W-1:0]   CHIP1_DATA_OUT,
  output logic [NIB_W-1:0]   CHIP2_DATA_OUT,
  output logic               DATA_OE,
  output logic [CNT_W-1:0]   COUNT,
  output logic [7:0]         WR_TOTAL,
  output logic               OVF
);

  localparam int          DW        = 2 * NIB_W;
  localparam int          MEM_DEPTH = 1 << MEM_AW;
  localparam logic [2:0]  TURN_LD   = 3'(TURN_CYC);

  typedef enum logic [1:0] {ST_FLOAT = 2'd0, ST_TURN = 2'd1, ST_DRIVE = 2'd2} state_t;

  logic             r_cclk_s1, r_cclk_s2, r_cclk_s3;
  logic             r_crst_s1, r_crst_s2;
  logic             r_we_s1, r_we_s2;
  logic [NIB_W-1:0] r_d1_s1, r_d1_s2;
  logic [NIB_W-1:0] r_d2_s1, r_d2_s2;

  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_wr_total;
  logic             r_ovf;
  logic [DW-1:0]    r_mem [MEM_DEPTH];

  state_t           r_state;
  logic [2:0]       r_turn_cnt;
  logic             r_oe;
  logic [DW-1:0]    r_rd_data;

  logic             w_rise;
  logic             w_fall;
  logic             w_wr_en;
  logic [MEM_AW-1:0] w_addr;
  logic [DW-1:0]    w_rd_data;

  // Strobes and data share one two-stage pipeline so they stay aligned; third clk flop feeds edge detect
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cclk_s1 <= 1'b0;
      r_cclk_s2 <= 1'b0;
      r_cclk_s3 <= 1'b0;
      r_crst_s1 <= 1'b0;
      r_crst_s2 <= 1'b0;
      r_we_s1   <= 1'b0;
      r_we_s2   <= 1'b0;
      r_d1_s1   <= '0;
      r_d1_s2   <= '0;
      r_d2_s1   <= '0;
      r_d2_s2   <= '0;
    end else begin
      r_cclk_s1 <= COUNTER_CLK;
      r_cclk_s2 <= r_cclk_s1;
      r_cclk_s3 <= r_cclk_s2;
      r_crst_s1 <= COUNTER_RST;
      r_crst_s2 <= r_crst_s1;
      r_we_s1   <= WE_BAR;
      r_we_s2   <= r_we_s1;
      r_d1_s1   <= CHIP1_DATA_IN;
      r_d1_s2   <= r_d1_s1;
      r_d2_s1   <= CHIP2_DATA_IN;
      r_d2_s2   <= r_d2_s1;
    end
  end

  assign w_rise  = r_cclk_s2 & ~r_cclk_s3;
  assign w_fall  = ~r_cclk_s2 & r_cclk_s3;
  assign w_wr_en = w_rise & ~r_we_s2 & ~r_crst_s2;
  assign w_addr  = r_count[MEM_AW-1:0];

  // Read path; the fault build corrupts only what leaves the chip, never the stored word
  always_comb begin
    w_rd_data = r_mem[w_addr];
`ifdef SRAM_EMU_FAULT_INJECT_EN
    if (w_addr == MEM_AW'(FAULT_ADDR)) begin
      w_rd_data[0] = ~r_mem[w_addr][0];
    end else begin
      w_rd_data[0] = r_mem[w_addr][0];
    end
`endif
  end

  // Negative-edge counter; counter clear wins over a coincident falling edge, wrap flag is sticky
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (r_crst_s2) begin
      r_count <= '0;
    end else if (w_fall) begin
      r_count <= r_count + CNT_W'(1);
      if (&r_count) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Saturating tally of committed writes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_total <= 8'd0;
    end else if (w_wr_en && (r_wr_total != 8'hFF)) begin
      r_wr_total <= r_wr_total + 8'd1;
    end
  end

  // Storage array; contents survive reset like the real part
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem[w_addr] <= {r_d1_s2, r_d2_s2};
    end
  end

  // Bus turnaround: the float interval after WE_BAR rises is TURN_CYC cycles spent in TURN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_FLOAT;
      r_turn_cnt <= 3'd0;
      r_oe       <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      case (r_state)
        ST_FLOAT: begin
          r_oe <= 1'b0;
          if (r_we_s2) begin
            if (TURN_LD == 3'd0) begin
              r_state   <= ST_DRIVE;
              r_oe      <= 1'b1;
              r_rd_data <= w_rd_data;
            end else begin
              r_state    <= ST_TURN;
              r_turn_cnt <= TURN_LD;
            end
          end
        end
        ST_TURN: begin
          if (!r_we_s2) begin
            r_state <= ST_FLOAT;
            r_oe    <= 1'b0;
          end else if (r_turn_cnt <= 3'd1) begin
            r_state    <= ST_DRIVE;
            r_turn_cnt <= 3'd0;
            r_oe       <= 1'b1;
            r_rd_data  <= w_rd_data;
          end else begin
            r_turn_cnt <= r_turn_cnt - 3'd1;
          end
        end
        ST_DRIVE: begin
          if (!r_we_s2) begin
            r_state <= ST_FLOAT;
            r_oe    <= 1'b0;
          end else begin
            r_rd_data <= w_rd_data;
          end
        end
        default: begin
          r_state <= ST_FLOAT;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign CHIP1_DATA_OUT = r_rd_data[DW-1:NIB_W];
  assign CHIP2_DATA_OUT = r_rd_data[NIB_W-1:0];
  assign DATA_OE        = r_oe;
  assign COUNT          = r_count;
  assign WR_TOTAL       = r_wr_total;
  assign OVF            = r_ovf;

endmodule

// File: tb/tb_sram_counter_emulator.sv
// Directed bench for sram_counter_emulator: a TURN_CYC=1 instance plus a TURN_CYC=3 instance on shared pins.
module tb_sram_counter_emulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cclk;
  logic       crst;
  logic       we_bar;
  logic [3:0] d1;
  logic [3:0] d2;

  logic [3:0]  o1, o2, o1_3, o2_3;
  logic        oe, oe_3;
  logic [11:0] count, count_3;
  logic [7:0]  wr_total, wr_total_3;
  logic        ovf, ovf_3;

  int checks = 0;
  int errors = 0;

  sram_counter_emulator #(.TURN_CYC(1)) u_dut (
    .CLK(clk), .RST(rst), .COUNTER_CLK(cclk), .COUNTER_RST(crst), .WE_BAR(we_bar),
    .CHIP1_DATA_IN(d1), .CHIP2_DATA_IN(d2), .CHIP1_DATA_OUT(o1), .CHIP2_DATA_OUT(o2),
    .DATA_OE(oe), .COUNT(count), .WR_TOTAL(wr_total), .OVF(ovf)
  );

  sram_counter_emulator #(.TURN_CYC(3)) u_dut3 (
    .CLK(clk), .RST(rst), .COUNTER_CLK(cclk), .COUNTER_RST(crst), .WE_BAR(we_bar),
    .CHIP1_DATA_IN(d1), .CHIP2_DATA_IN(d2), .CHIP1_DATA_OUT(o1_3), .CHIP2_DATA_OUT(o2_3),
    .DATA_OE(oe_3), .COUNT(count_3), .WR_TOTAL(wr_total_3), .OVF(ovf_3)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // count advances 6 CLK into the pulse; the read register follows one CLK later
  task automatic pulse_cclk();
    cclk = 1'b1;
    tick(3);
    cclk = 1'b0;
    tick(4);
  endtask

  task automatic pulse_crst();
    crst = 1'b1;
    tick(4);
    crst = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; cclk = 1'b0; crst = 1'b0; we_bar = 1'b0; d1 = 4'h0; d2 = 4'h0;
    tick(3);
    checks++; if (count !== 12'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", oe); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (wr_total !== 8'd0) begin errors++; $display("FAIL reset_wr_total: got %0d expected 0", wr_total); end
    checks++; if ({o1, o2} !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", {o1, o2}); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_write_loop();
    logic [7:0] wd;
    we_bar = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wd = 8'h3A + 8'(i);
      {d1, d2} = wd;
      pulse_cclk();
    end
    checks++; if (wr_total !== 8'd16) begin errors++; $display("FAIL write_total: got %0d expected 16", wr_total); end
    checks++; if (count !== 12'd16) begin errors++; $display("FAIL write_count: got %0d expected 16", count); end
  endtask

  task automatic test_read_loop();
    logic [7:0] exp_d;
    pulse_crst();
    checks++; if (count !== 12'd0) begin errors++; $display("FAIL crst_count: got %0d expected 0", count); end
    we_bar = 1'b1;
    tick(3);
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL oe_early: got %b expected 0 at 3 CLK", oe); end
    tick(1);
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL oe_rise: got %b expected 1 at 4 CLK", oe); end
    for (int i = 0; i < 16; i++) begin
      exp_d = 8'h3A + 8'(i);
`ifdef SRAM_EMU_FAULT_INJECT_EN
      if (i == 5) exp_d = 8'h3E;
`endif
      checks++;
      if ({o1, o2} !== exp_d) begin
        errors++; $display("FAIL read_data[%0d]: got %h expected %h", i, {o1, o2}, exp_d);
      end
      pulse_cclk();
    end
    checks++; if (wr_total !== 8'd16) begin errors++; $display("FAIL read_no_write: got %0d expected 16", wr_total); end
  endtask

  task automatic test_alias_wrap();
    pulse_crst();
    repeat (3) pulse_cclk();
    we_bar = 1'b0;
    {d1, d2} = 8'hC5;
    pulse_cclk();
    we_bar = 1'b1;
    repeat (15) pulse_cclk();
    checks++; if (count !== 12'd19) begin errors++; $display("FAIL alias_count: got %0d expected 19", count); end
    checks++; if ({o1, o2} !== 8'hC5) begin errors++; $display("FAIL alias_data: got %h expected c5", {o1, o2}); end
    checks++; if (wr_total !== 8'd17) begin errors++; $display("FAIL alias_total: got %0d expected 17", wr_total); end
    repeat (4095 - 19) pulse_cclk();
    checks++; if (count !== 12'd4095) begin errors++; $display("FAIL prewrap_count: got %0d expected 4095", count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL prewrap_ovf: got %b expected 0", ovf); end
    pulse_cclk();
    checks++; if (count !== 12'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", count); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf: got %b expected 1", ovf); end
    pulse_crst();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
  endtask

  task automatic test_reset_priority();
    crst = 1'b1;
    tick(3);
    we_bar = 1'b0;
    {d1, d2} = 8'h99;
    pulse_cclk();
    checks++; if (count !== 12'd0) begin errors++; $display("FAIL prio_count: got %0d expected 0", count); end
    checks++; if (wr_total !== 8'd17) begin errors++; $display("FAIL prio_total: got %0d expected 17", wr_total); end
    crst = 1'b0;
    we_bar = 1'b1;
    tick(6);
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL prio_oe: got %b expected 1", oe); end
    checks++; if ({o1, o2} !== 8'h3A) begin errors++; $display("FAIL prio_mem0: got %h expected 3a", {o1, o2}); end
  endtask

  task automatic test_turn_abort();
    we_bar = 1'b0;
    tick(5);
    we_bar = 1'b1;
    tick(1);
    we_bar = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++; if (oe_3 !== 1'b0) begin errors++; $display("FAIL abort_oe3[%0d]: got %b expected 0", i, oe_3); end
      checks++; if (oe !== 1'b0) begin errors++; $display("FAIL abort_oe1[%0d]: got %b expected 0", i, oe); end
    end
    we_bar = 1'b1;
    tick(5);
    checks++; if (oe_3 !== 1'b0) begin errors++; $display("FAIL turn3_early: got %b expected 0 at 5 CLK", oe_3); end
    tick(1);
    checks++; if (oe_3 !== 1'b1) begin errors++; $display("FAIL turn3_rise: got %b expected 1 at 6 CLK", oe_3); end
  endtask

  task automatic test_fault_inject();
    logic [7:0] exp_tab [8];
    exp_tab[0] = 8'h3A; exp_tab[1] = 8'h3B; exp_tab[2] = 8'h3C; exp_tab[3] = 8'hC5;
    exp_tab[4] = 8'h3E;
`ifdef SRAM_EMU_FAULT_INJECT_EN
    exp_tab[5] = 8'h3E;
`else
    exp_tab[5] = 8'h3F;
`endif
    exp_tab[6] = 8'h40; exp_tab[7] = 8'h41;
    pulse_crst();
    repeat (5) pulse_cclk();
    we_bar = 1'b0;
    {d1, d2} = 8'h3F;
    pulse_cclk();
    we_bar = 1'b1;
    pulse_crst();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({o1, o2} !== exp_tab[i]) begin
        errors++; $display("FAIL fault_read[%0d]: got %h expected %h", i, {o1, o2}, exp_tab[i]);
      end
      if (i < 7) pulse_cclk();
    end
    checks++; if (wr_total !== 8'd18) begin errors++; $display("FAIL fault_total: got %0d expected 18", wr_total); end
  endtask

  task automatic test_reset_mid_drive();
    checks++; if (count !== 12'd7) begin errors++; $display("FAIL pre_rst_count: got %0d expected 7", count); end
    checks++; if (oe !== 1'b1) begin errors++; $display("FAIL pre_rst_oe: got %b expected 1", oe); end
    rst = 1'b1;
    #1;
    checks++; if (count !== 12'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b expected 0", oe); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    checks++; if (wr_total !== 8'd0) begin errors++; $display("FAIL rst_total: got %0d expected 0", wr_total); end
    checks++; if ({o1, o2} !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", {o1, o2}); end
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_write_loop();
    test_read_loop();
    test_alias_wrap();
    test_reset_priority();
    test_turn_abort();
    test_fault_inject();
    test_reset_mid_drive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
